// File: rtl/pc_fetch_unit.sv
// IF stage: PC ownership, instruction-memory req/ready handshake, IF/ID register, redirect/flush handling.
// Optional MISALIGN output is enabled by defining MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_SELECT,
  input  logic [31:0] TARGET_ADDRESS,
  input  logic        STALL,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_READY,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID,
`ifdef MISALIGN_TRAP_EN
  output logic        MISALIGN,
`endif
  output logic        FLUSH_OUT
);

  // state   | meaning
  // IDLE    | first cycle after reset, no request yet
  // FETCH   | request at pc outstanding
  // HOLD    | fetched word parked in skid buffer while IF/ID is stalled
  // DISCARD | wrong-path request still in flight; word dropped, then fetch at pend_target
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_target;
  logic [31:0] skid_pc;
  logic [31:0] skid_data;
  logic [31:0] if_pc_q, if_pc4_q, if_instr_q;
  logic        if_valid_q;
  logic        flush_q;
  logic        misalign_q;
  logic [31:0] tgt_aligned;

  assign tgt_aligned = {TARGET_ADDRESS[31:2], 2'b00};

  assign IMEM_REQ  = (state == FETCH) || (state == DISCARD);
  assign IMEM_ADDR = pc;
  assign IF_PC     = if_pc_q;
  assign IF_PC4    = if_pc4_q;
  assign IF_INSTR  = if_instr_q;
  assign IF_VALID  = if_valid_q;
  assign FLUSH_OUT = flush_q;
`ifdef MISALIGN_TRAP_EN
  assign MISALIGN  = misalign_q;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      pend_target <= RESET_VECTOR;
      skid_pc     <= 32'h0;
      skid_data   <= NOP_INSN;
      if_pc_q     <= 32'h0;
      if_pc4_q    <= 32'h0;
      if_instr_q  <= NOP_INSN;
      if_valid_q  <= 1'b0;
      flush_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      if (BRANCH_SELECT) begin
        flush_q    <= 1'b1;
        misalign_q <= |TARGET_ADDRESS[1:0];
        if_valid_q <= 1'b0;
        if_instr_q <= NOP_INSN;
        // A request already on the bus cannot be withdrawn, so park the target until it completes.
        if ((state == FETCH || state == DISCARD) && !IMEM_READY) begin
          state       <= DISCARD;
          pend_target <= tgt_aligned;
        end else begin
          state <= FETCH;
          pc    <= tgt_aligned;
        end
      end else begin
        case (state)
          IDLE: state <= FETCH;
          FETCH: begin
            if (IMEM_READY && !STALL) begin
              if_pc_q    <= pc;
              if_pc4_q   <= pc + 32'd4;
              if_instr_q <= IMEM_RDATA;
              if_valid_q <= 1'b1;
              pc         <= pc + 32'd4;
            end else if (IMEM_READY && STALL) begin
              skid_pc   <= pc;
              skid_data <= IMEM_RDATA;
              state     <= HOLD;
            end else if (!STALL) begin
              if_valid_q <= 1'b0;
              if_instr_q <= NOP_INSN;
            end
          end
          HOLD: begin
            if (!STALL) begin
              if_pc_q    <= skid_pc;
              if_pc4_q   <= skid_pc + 32'd4;
              if_instr_q <= skid_data;
              if_valid_q <= 1'b1;
              pc         <= pc + 32'd4;
              state      <= FETCH;
            end
          end
          DISCARD: begin
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSN;
            if (IMEM_READY) begin
              pc    <= pend_target;
              state <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; memory returns its address as the instruction word.
// Checks MISALIGN as well when built with MISALIGN_TRAP_EN.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BRANCH_SELECT;
  logic [31:0] TARGET_ADDRESS;
  logic        STALL;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READY;
  logic [31:0] IMEM_RDATA;
  logic [31:0] IF_PC, IF_PC4, IF_INSTR;
  logic        IF_VALID;
  logic        FLUSH_OUT;
`ifdef MISALIGN_TRAP_EN
  logic        MISALIGN;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;
  assign IMEM_RDATA = IMEM_ADDR;

  pc_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .BRANCH_SELECT(BRANCH_SELECT), .TARGET_ADDRESS(TARGET_ADDRESS),
    .STALL(STALL), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_READY(IMEM_READY),
    .IMEM_RDATA(IMEM_RDATA), .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_INSTR(IF_INSTR),
    .IF_VALID(IF_VALID),
`ifdef MISALIGN_TRAP_EN
    .MISALIGN(MISALIGN),
`endif
    .FLUSH_OUT(FLUSH_OUT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; BRANCH_SELECT = 1'b0; TARGET_ADDRESS = 32'h0; STALL = 1'b0; IMEM_READY = 1'b1;
    step();
    chk("rst_req", {31'b0, IMEM_REQ}, 32'd0);
    chk("rst_valid", {31'b0, IF_VALID}, 32'd0);
    chk("rst_instr", IF_INSTR, NOP);
    chk("rst_pc", IF_PC, 32'h0);
    chk("rst_pc4", IF_PC4, 32'h0);
    chk("rst_flush", {31'b0, FLUSH_OUT}, 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_misalign", {31'b0, MISALIGN}, 32'd0);
`endif
    RESET = 1'b1;
    step();
    chk("idle_exit_req", {31'b0, IMEM_REQ}, 32'd1);
    chk("addr0", IMEM_ADDR, 32'h0);
    chk("valid_before_first", {31'b0, IF_VALID}, 32'd0);
    step();
    chk("addr4", IMEM_ADDR, 32'h4);
    chk("ifpc0", IF_PC, 32'h0);
    chk("valid0", {31'b0, IF_VALID}, 32'd1);
    step();
    chk("addr8", IMEM_ADDR, 32'h8);
    chk("ifpc4", IF_PC, 32'h4);
    chk("instr4", IF_INSTR, 32'h4);
    step();
    chk("ifpc8", IF_PC, 32'h8);
    chk("pc4_of_8", IF_PC4, 32'hC);
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req", {31'b0, IMEM_REQ}, 32'd0);
      chk("stall_ifpc", IF_PC, 32'h8);
      chk("stall_instr", IF_INSTR, 32'h8);
      chk("stall_valid", {31'b0, IF_VALID}, 32'd1);
    end
    STALL = 1'b0;
    step();
    chk("unstall_ifpc", IF_PC, 32'hC);
    chk("unstall_instr", IF_INSTR, 32'hC);
    chk("unstall_addr", IMEM_ADDR, 32'h10);
    chk("unstall_req", {31'b0, IMEM_REQ}, 32'd1);
    step();
    chk("ifpc10", IF_PC, 32'h10);
    chk("addr14", IMEM_ADDR, 32'h14);
    // Redirect to 0x200 while the 0x14 request is stuck waiting.
    IMEM_READY = 1'b0; BRANCH_SELECT = 1'b1; TARGET_ADDRESS = 32'h200;
    step();
    chk("disc_flush", {31'b0, FLUSH_OUT}, 32'd1);
    chk("disc_valid", {31'b0, IF_VALID}, 32'd0);
    chk("disc_addr_a", IMEM_ADDR, 32'h14);
    chk("disc_req", {31'b0, IMEM_REQ}, 32'd1);
    BRANCH_SELECT = 1'b0; STALL = 1'b1;
    step();
    chk("disc_addr_b", IMEM_ADDR, 32'h14);
    chk("disc_flush_off", {31'b0, FLUSH_OUT}, 32'd0);
    IMEM_READY = 1'b1;
    step();
    chk("disc_drop_valid", {31'b0, IF_VALID}, 32'd0);
    chk("disc_new_addr", IMEM_ADDR, 32'h200);
    STALL = 1'b0;
    step();
    chk("ifpc200", IF_PC, 32'h200);
    chk("valid200", {31'b0, IF_VALID}, 32'd1);
    BRANCH_SELECT = 1'b1; TARGET_ADDRESS = 32'h100;
    step();
    chk("br_flush", {31'b0, FLUSH_OUT}, 32'd1);
    chk("br_valid", {31'b0, IF_VALID}, 32'd0);
    chk("br_instr", IF_INSTR, NOP);
    chk("br_addr", IMEM_ADDR, 32'h100);
    BRANCH_SELECT = 1'b0;
    step();
    chk("br_ifpc", IF_PC, 32'h100);
    chk("br_ifpc4", IF_PC4, 32'h104);
    chk("br_flush_off", {31'b0, FLUSH_OUT}, 32'd0);
    BRANCH_SELECT = 1'b1; TARGET_ADDRESS = 32'h103;
    step();
    chk("mis_addr", IMEM_ADDR, 32'h100);
`ifdef MISALIGN_TRAP_EN
    chk("mis_pulse", {31'b0, MISALIGN}, 32'd1);
`endif
    BRANCH_SELECT = 1'b0;
    step();
    chk("mis_ifpc", IF_PC, 32'h100);
`ifdef MISALIGN_TRAP_EN
    chk("mis_clear", {31'b0, MISALIGN}, 32'd0);
`endif
    // Enter DISCARD, then reset in it.
    IMEM_READY = 1'b0; BRANCH_SELECT = 1'b1; TARGET_ADDRESS = 32'h300;
    step();
    chk("disc2_addr", IMEM_ADDR, 32'h104);
    BRANCH_SELECT = 1'b0; RESET = 1'b0;
    step();
    chk("rst2_req", {31'b0, IMEM_REQ}, 32'd0);
    chk("rst2_valid", {31'b0, IF_VALID}, 32'd0);
    chk("rst2_instr", IF_INSTR, NOP);
    chk("rst2_pc", IF_PC, 32'h0);
    chk("rst2_pc4", IF_PC4, 32'h0);
    chk("rst2_flush", {31'b0, FLUSH_OUT}, 32'd0);
    RESET = 1'b1; IMEM_READY = 1'b1;
    step();
    chk("rst2_first_addr", IMEM_ADDR, 32'h0);
    chk("rst2_first_req", {31'b0, IMEM_REQ}, 32'd1);
    BRANCH_SELECT = 1'b1; TARGET_ADDRESS = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    BRANCH_SELECT = 1'b0;
    step();
    chk("wrap_ifpc", IF_PC, 32'hFFFF_FFFC);
    chk("wrap_ifpc4", IF_PC4, 32'h0);
    chk("wrap_next_addr", IMEM_ADDR, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
